// File: rtl/seven_segment_reader.sv
// Recovers the nibble shown on each digit of a multiplexed active-high seven-segment bus.
// Define SEVSEG_READER_HEX_EN to also accept the A..F glyphs.
module seven_segment_reader #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned STABLE_COUNT = 3,
    parameter int unsigned TIMEOUT      = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    sample_en,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic                    stale
);
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  CntMax = 4'(STABLE_COUNT);
    localparam logic [TW-1:0] TLimit = TW'(TIMEOUT);

    // Returns {legal, blank, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b0000000: r = 6'b11_0000;
            7'b1111110: r = 6'b10_0000;
            7'b0110000: r = 6'b10_0001;
            7'b1101101: r = 6'b10_0010;
            7'b1111001: r = 6'b10_0011;
            7'b0110011: r = 6'b10_0100;
            7'b1011011: r = 6'b10_0101;
            7'b1011111: r = 6'b10_0110;
            7'b1110000: r = 6'b10_0111;
            7'b1111111: r = 6'b10_1000;
            7'b1111011: r = 6'b10_1001;
`ifdef SEVSEG_READER_HEX_EN
            7'b1110111: r = 6'b10_1010;
            7'b0011111: r = 6'b10_1011;
            7'b1001110: r = 6'b10_1100;
            7'b0111101: r = 6'b10_1101;
            7'b1001111: r = 6'b10_1110;
            7'b1000111: r = 6'b10_1111;
`endif
            default:    r = 6'b00_0000;
        endcase
        return r;
    endfunction

    logic [NUM_DIGITS-1:0][4:0] cand_q, cand_d;
    logic [NUM_DIGITS-1:0][3:0] cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]    digits_q, digits_d;
    logic [NUM_DIGITS-1:0]      valid_q, valid_d;
    logic [TW-1:0]              tcnt_q, tcnt_d;
    logic                       stale_q, stale_d;
    logic                       update_q, update_d;
    logic                       err_q, err_d;
    logic [1:0]                 code_q, code_d;

    logic       dec_legal, dec_blank;
    logic [3:0] dec_nib;
    logic       sel_onehot;
    logic       match;

    assign {dec_legal, dec_blank, dec_nib} = decode(seg);
    assign sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        valid_d  = valid_q;
        tcnt_d   = tcnt_q;
        stale_d  = stale_q;
        err_d    = 1'b0;
        code_d   = 2'b00;
        match    = 1'b0;
        if (sample_en) begin
            tcnt_d  = '0;
            stale_d = 1'b0;
            if (!sel_onehot) begin
                err_d  = 1'b1;
                code_d = 2'b10;
            end else begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (dig_sel[k]) begin
                        if (!dec_legal) begin
                            err_d    = 1'b1;
                            code_d   = 2'b01;
                            cnt_d[k] = '0;
                        end else begin
                            match = (cand_q[k] == {dec_blank, dec_nib}) && (cnt_q[k] != '0);
                            if (match) begin
                                if (cnt_q[k] != CntMax) cnt_d[k] = cnt_q[k] + 4'd1;
                            end else begin
                                cand_d[k] = {dec_blank, dec_nib};
                                cnt_d[k]  = 4'd1;
                            end
                            // Only the sample that brings the count up to CntMax commits.
                            if (cnt_d[k] == CntMax && !(match && cnt_q[k] == CntMax)) begin
                                digits_d[4*k +: 4] = dec_nib;
                                valid_d[k]         = ~dec_blank;
                            end
                        end
                    end
                end
            end
        end else if (tcnt_q != TLimit) begin
            tcnt_d = tcnt_q + TW'(1);
            if (tcnt_d == TLimit) begin
                stale_d = 1'b1;
                valid_d = '0;
                cnt_d   = '0;
                err_d   = 1'b1;
                code_d  = 2'b11;
            end
        end
        update_d = (digits_d != digits_q) || (valid_d != valid_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            tcnt_q   <= '0;
            stale_q  <= 1'b0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            tcnt_q   <= tcnt_d;
            stale_q  <= stale_d;
            update_q <= update_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: a run-length reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seven_segment_reader;
    localparam int ND = 4;
    localparam int SC = 3;
    localparam int TO = 40;
`ifdef SEVSEG_READER_HEX_EN
    localparam int NGLYPH = 16;
`else
    localparam int NGLYPH = 10;
`endif
    localparam logic [6:0] PAT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
        7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    seg;
    logic [ND-1:0] dig_sel;
    logic          sample_en;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid;
    logic          update, err, stale;
    logic [1:0]    err_code;

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_COUNT(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .seg(seg), .dig_sel(dig_sel), .sample_en(sample_en),
        .digits(digits), .digit_valid(digit_valid), .update(update), .err(err),
        .err_code(err_code), .stale(stale)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Glyph value 0..15, 16 for blank, -1 when the pattern is not a legal glyph.
    function automatic int glyph_value(input logic [6:0] s);
        if (s == 7'd0) return 16;
        for (int v = 0; v < NGLYPH; v++) if (PAT[v] == s) return v;
        return -1;
    endfunction

    // Reference model: length of the current run of identical legal samples per digit.
    int          run_val [ND];
    int          run_len [ND];
    int          idle;
    int          sel_idx;
    int          gv;
    logic [4*ND-1:0] m_digits, old_d;
    logic [ND-1:0]   m_valid, old_v;
    logic        m_stale, e_update, e_err;
    logic [1:0]  e_code;

    always @(posedge clk) begin
        old_d  = m_digits;
        old_v  = m_valid;
        e_err  = 1'b0;
        e_code = 2'b00;
        if (reset) begin
            for (int k = 0; k < ND; k++) begin run_val[k] = 0; run_len[k] = 0; end
            idle = 0; m_digits = '0; m_valid = '0; m_stale = 1'b0;
        end else if (sample_en) begin
            idle = 0;
            m_stale = 1'b0;
            if ($countones(dig_sel) != 1) begin
                e_err = 1'b1; e_code = 2'b10;
            end else begin
                for (int k = 0; k < ND; k++) if (dig_sel[k]) sel_idx = k;
                gv = glyph_value(seg);
                if (gv < 0) begin
                    e_err = 1'b1; e_code = 2'b01;
                    run_len[sel_idx] = 0;
                end else begin
                    if (run_len[sel_idx] > 0 && run_val[sel_idx] == gv) begin
                        run_len[sel_idx]++;
                    end else begin
                        run_val[sel_idx] = gv;
                        run_len[sel_idx] = 1;
                    end
                    if (run_len[sel_idx] == SC) begin
                        m_digits[4*sel_idx +: 4] = (gv == 16) ? 4'd0 : 4'(gv);
                        m_valid[sel_idx] = (gv != 16);
                    end
                end
            end
        end else begin
            idle++;
            if (idle == TO) begin
                m_stale = 1'b1; m_valid = '0;
                for (int k = 0; k < ND; k++) run_len[k] = 0;
                e_err = 1'b1; e_code = 2'b11;
            end
        end
        e_update = !reset && ((m_digits != old_d) || (m_valid != old_v));
        #1;
        chk("model_digits", 32'(digits), 32'(m_digits));
        chk("model_valid", 32'(digit_valid), 32'(m_valid));
        chk("model_update", 32'(update), 32'(e_update));
        chk("model_err", 32'(err), 32'(e_err));
        chk("model_err_code", 32'(err_code), 32'(e_code));
        chk("model_stale", 32'(stale), 32'(m_stale));
    end

    task automatic smp(input logic [ND-1:0] s, input logic [6:0] p);
        sample_en = 1'b1; dig_sel = s; seg = p;
        @(negedge clk);
        sample_en = 1'b0; dig_sel = '0; seg = '0;
    endtask

    initial begin
        reset = 1'b1; sample_en = 1'b0; dig_sel = '0; seg = '0;
        repeat (3) @(negedge clk);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_valid", 32'(digit_valid), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_stale", 32'(stale), 32'h0);
        reset = 1'b0;

        // Three identical samples of "3" on digit 0.
        smp(4'b0001, 7'b1111001);
        smp(4'b0001, 7'b1111001);
        chk("no_commit_after_2", 32'(digit_valid), 32'h0);
        chk("no_update_after_2", 32'(update), 32'h0);
        smp(4'b0001, 7'b1111001);
        chk("commit_3", 32'(digits[3:0]), 32'h3);
        chk("commit_3_valid", 32'(digit_valid), 32'h1);
        chk("commit_3_update", 32'(update), 32'h1);
        @(negedge clk);
        chk("update_one_cycle", 32'(update), 32'h0);

        // 5,5 then 6,6,6 on digit 1: the interrupted 5 never commits.
        smp(4'b0010, 7'b1011011);
        smp(4'b0010, 7'b1011011);
        smp(4'b0010, 7'b1011111);
        smp(4'b0010, 7'b1011111);
        chk("no_commit_5", 32'(digit_valid[1]), 32'h0);
        chk("no_commit_5_digit", 32'(digits[7:4]), 32'h0);
        smp(4'b0010, 7'b1011111);
        chk("commit_6", 32'(digits[7:4]), 32'h6);
        chk("commit_6_valid", 32'(digit_valid), 32'h3);

        // Hex glyph "A" on digit 0.
`ifdef SEVSEG_READER_HEX_EN
        repeat (3) smp(4'b0001, 7'b1110111);
        chk("hex_a_commit", 32'(digits[3:0]), 32'hA);
        chk("hex_a_valid", 32'(digit_valid[0]), 32'h1);
`else
        smp(4'b0001, 7'b1110111);
        chk("illegal_err", 32'(err), 32'h1);
        chk("illegal_code", 32'(err_code), 32'h1);
        chk("illegal_keeps_digit", 32'(digits[3:0]), 32'h3);
        @(negedge clk);
        chk("illegal_err_pulse", 32'(err), 32'h0);
`endif

        // Two "7"s on digit 2, bad selects, then the third "7" still commits.
        smp(4'b0100, 7'b1110000);
        smp(4'b0100, 7'b1110000);
        smp(4'b0011, 7'b1111111);
        chk("badsel_multi_code", 32'(err_code), 32'h2);
        chk("badsel_multi_err", 32'(err), 32'h1);
        smp(4'b0000, 7'b1111111);
        chk("badsel_zero_code", 32'(err_code), 32'h2);
        chk("badsel_no_change", 32'(digits[11:8]), 32'h0);
        smp(4'b0100, 7'b1110000);
        chk("commit_7_after_badsel", 32'(digits[11:8]), 32'h7);
        chk("commit_7_valid", 32'(digit_valid[2]), 32'h1);

        // "9" on digit 3, then idle into timeout.
        repeat (3) smp(4'b1000, 7'b1111011);
        chk("all_valid", 32'(digit_valid), 32'hF);
        repeat (TO - 1) @(negedge clk);
        chk("not_stale_yet", 32'(stale), 32'h0);
        @(negedge clk);
        chk("stale_set", 32'(stale), 32'h1);
        chk("timeout_err", 32'(err), 32'h1);
        chk("timeout_code", 32'(err_code), 32'h3);
        chk("timeout_valid", 32'(digit_valid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("timeout_single_pulse", 32'(err), 32'h0);
            chk("stale_holds", 32'(stale), 32'h1);
        end
        chk("stale_keeps_digits", 32'(digits[15:12]), 32'h9);
        smp(4'b0100, 7'b1111110);
        chk("stale_cleared", 32'(stale), 32'h0);

        // Commit "8" on digit 0, then blank it.
        repeat (3) smp(4'b0001, 7'b1111111);
        chk("commit_8", 32'(digits[3:0]), 32'h8);
        chk("commit_8_valid", 32'(digit_valid[0]), 32'h1);
        smp(4'b0001, 7'b0000000);
        smp(4'b0001, 7'b0000000);
        chk("blank_pending", 32'(digit_valid[0]), 32'h1);
        chk("blank_no_update", 32'(update), 32'h0);
        smp(4'b0001, 7'b0000000);
        chk("blank_valid", 32'(digit_valid[0]), 32'h0);
        chk("blank_digit", 32'(digits[3:0]), 32'h0);
        chk("blank_update", 32'(update), 32'h1);

        // Reset in the middle of a scan, with a sample in flight.
        smp(4'b0010, 7'b1111001);
        smp(4'b0010, 7'b1111001);
        reset = 1'b1; sample_en = 1'b1; dig_sel = 4'b0010; seg = 7'b1111001;
        @(negedge clk);
        reset = 1'b0; sample_en = 1'b0; dig_sel = '0; seg = '0;
        chk("midreset_digits", 32'(digits), 32'h0);
        chk("midreset_valid", 32'(digit_valid), 32'h0);
        chk("midreset_update", 32'(update), 32'h0);
        chk("midreset_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
